sram_regs_master: RTL and testbench
===================================

# sram_regs_master

AXI4-Lite single-outstanding master that turns a simple command/response stream into register reads and writes. It is the initiator counterpart of the SRAM packet-generator register file. It sits between a configuration sequencer (host-command decoder or self-test FSM) and the AXI-Lite slave port of that register file. It adds a per-transaction timeout so that a dead slave cannot hang the sequencer.

## Interface
- DATA_WIDTH, 32, AXI data width; cmd/rsp data width.
- ADDR_WIDTH, 32, AXI address width.
- TIMEOUT, 1024, cycles from command acceptance to forced completion; must be ≥2; counter width is clog2(TIMEOUT+1).
- ACLK  in  1  clock.
- ARESETN  in  1  synchronous, active-low reset.
- cmd_valid, cmd_ready  in/out  1  command handshake.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  register byte address, passed unmodified.
- cmd_wdata  in  DATA_WIDTH  write data.
- cmd_wstrb  in  DATA_WIDTH/8  write strobes.
- rsp_valid, rsp_ready  out/in  1  response handshake.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and timeouts.
- rsp_resp  out  2  AXI response code (00 OK, 10 SLVERR).
- rsp_timeout  out  1  transaction ended by timeout.
- stray_cnt  out  8  saturating count of B/R beats that arrive while no transaction is waiting for them.
- AWADDR/AWVALID/AWREADY, WDATA/WSTRB/WVALID/WREADY, BRESP/BVALID/BREADY, ARADDR/ARVALID/ARREADY, RDATA/RRESP/RVALID/RREADY: standard AXI4-Lite master ports with widths from the parameters. AWPROT and ARPROT are not driven.

## Operation
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP.
- IDLE: cmd_ready=1. On cmd_valid&cmd_ready:
  - Latch addr, wdata, wstrb and direction.
  - Clear the timer.
  - Go to WR_REQ (write) or RD_REQ (read).
- WR_REQ:
  - AWVALID and WVALID both assert on entry.
  - Each is dropped independently on its own handshake; completion is tracked with aw_done and w_done flags.
  - AW and W may complete in either order or in the same cycle.
  - When both are done, go to WR_RESP.
- WR_RESP: BREADY=1. On BVALID, capture BRESP and go to RSP.
- RD_REQ: ARVALID=1 until ARREADY, then go to RD_RESP.
- RD_RESP: RREADY=1. On RVALID, capture RDATA and RRESP and go to RSP.
- RSP:
  - rsp_valid=1; rsp_* stay stable until rsp_ready.
  - On rsp_ready, return to IDLE.
  - cmd_ready=0 throughout.
- Timeout:
  - The timer increments every cycle in WR_REQ, WR_RESP, RD_REQ and RD_RESP.
  - When the timer reaches TIMEOUT: rsp_resp=10, rsp_timeout=1, rsp_rdata=0, go to RSP.
  - All AXI valids deassert the following cycle. This is a deliberate recovery-only violation; the slave is presumed dead.
  - If a handshake completes in the same cycle as timer expiry, the handshake wins and no timeout is reported.
- Outside WR_RESP and RD_RESP, BREADY and RREADY are held at 1 so that late or stray beats are sunk rather than left blocking the slave.
  - Each such accepted beat increments stray_cnt, which saturates at 255.
- Write strobes are forwarded as given; this block never converts partial-strobe writes.

## Timing
- Reset values:
  - All VALIDs = 0; cmd_ready=0 during reset and 1 the first cycle after.
  - BREADY=1, RREADY=1 (IDLE sink behaviour).
  - rsp_valid=0, rsp_rdata=0, rsp_resp=00, rsp_timeout=0, stray_cnt=0.
  - AWADDR, ARADDR, WDATA = 0; WSTRB = 0.
- All AXI and rsp outputs are registered or are direct state decodes; there is no combinational path from any AXI ready input to any AXI valid output.
- With cmd accepted at cycle 0:
  - AWVALID, WVALID and ARVALID are first high at cycle 1.
  - Against a zero-wait slave that accepts AW before W: AW handshake at cycle 1, W at cycle 2, B at cycle 3, rsp_valid at cycle 4.
  - Read against the same slave: AR at cycle 1, R at cycle 2, rsp_valid at cycle 3.
- Throughput: at most one transaction in flight. Next cmd_ready is the cycle after the rsp handshake.
- Reset mid-transaction: all valids drop the next cycle and the state returns to IDLE. No response is produced for the aborted command.

## Structure
- Shared package `sram_axil_pkg`:
  - AXI_RESP_OK, AXI_RESP_SLVERR.
  - The register offset constants (BASE 0x00–0x03, BOUND 0x10–0x13, TAIL 0x20–0x23, REPLAY_TIMES 0x30, REPLAY_BEGIN 0x31, HOST_RESET 0x32), so that sequencers and benches share them with the slave.
- The state enum stays local to this block.
- Single module; no sub-module. The timer and stray counter are inline.

## Test plan
- Write addr 0x10, data 0x0002_0000, wstrb 0xF, to the SRAM register slave → B OK; rsp_valid at cycle 4 with rsp_resp=00 and rsp_timeout=0; a read-back of 0x10 returns 0x0002_0000.
- Read 0x20 with the slave's tail_addr_0 tied to 0x1234 → rsp_valid at cycle 3, rsp_rdata=0x0000_1234, rsp_resp=00.
- Read 0x40 (unmapped) → rsp_resp=10 and rsp_timeout=0. A write to 0x40 also returns 10.
- TIMEOUT=16, slave with AWREADY stuck at 0 → rsp_valid at cycle 17 with rsp_resp=10, rsp_timeout=1, rsp_rdata=0; AWVALID low at cycle 17.
- Slave asserting WREADY before AWREADY, and a slave asserting both in the same cycle → exactly one AW and one W handshake each; correct B is captured.
- rsp_ready held low for 5 cycles, then a reset pulse mid-write, then an unsolicited BVALID in IDLE:
  - rsp outputs stay stable and cmd_ready stays 0 while rsp_ready is low.
  - After the reset, valids are 0 the next cycle.
  - The unsolicited BVALID takes stray_cnt from 0 to 1.

Source files
------------

// File: rtl/sram_axil_pkg.sv
// Shared AXI-Lite definitions for the SRAM packet-generator register file.
// Response codes, register byte offsets and an address-map helper.
package sram_axil_pkg;

   localparam logic [1:0] AXI_RESP_OK     = 2'b00;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

   localparam logic [7:0] REG_BASE_0       = 8'h00;
   localparam logic [7:0] REG_BASE_1       = 8'h01;
   localparam logic [7:0] REG_BASE_2       = 8'h02;
   localparam logic [7:0] REG_BASE_3       = 8'h03;
   localparam logic [7:0] REG_BOUND_0      = 8'h10;
   localparam logic [7:0] REG_BOUND_1      = 8'h11;
   localparam logic [7:0] REG_BOUND_2      = 8'h12;
   localparam logic [7:0] REG_BOUND_3      = 8'h13;
   localparam logic [7:0] REG_TAIL_0       = 8'h20;
   localparam logic [7:0] REG_TAIL_1       = 8'h21;
   localparam logic [7:0] REG_TAIL_2       = 8'h22;
   localparam logic [7:0] REG_TAIL_3       = 8'h23;
   localparam logic [7:0] REG_REPLAY_TIMES = 8'h30;
   localparam logic [7:0] REG_REPLAY_BEGIN = 8'h31;
   localparam logic [7:0] REG_HOST_RESET   = 8'h32;

   // True when the byte address hits one of the register slots above.
   function automatic logic reg_is_mapped(input logic [31:0] addr);
      logic hit;
      hit = 1'b0;
      if (addr[31:8] == 24'd0) begin
         hit = (addr[7:0] <= REG_BASE_3)
            || (addr[7:0] >= REG_BOUND_0 && addr[7:0] <= REG_BOUND_3)
            || (addr[7:0] >= REG_TAIL_0  && addr[7:0] <= REG_TAIL_3)
            || (addr[7:0] >= REG_REPLAY_TIMES
                && addr[7:0] <= REG_HOST_RESET);
      end
      return hit;
   endfunction

endpackage

// File: rtl/sram_regs_master.sv
// AXI4-Lite single-outstanding master: cmd stream in, rsp stream out,
// per-transaction timeout, saturating count of stray B/R beats.
module sram_regs_master #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int TIMEOUT    = 1024
) (
   input  logic                    ACLK,
   input  logic                    ARESETN,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic                    cmd_write,
   input  logic [ADDR_WIDTH-1:0]   cmd_addr,
   input  logic [DATA_WIDTH-1:0]   cmd_wdata,
   input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [DATA_WIDTH-1:0]   rsp_rdata,
   output logic [1:0]              rsp_resp,
   output logic                    rsp_timeout,
   output logic [7:0]              stray_cnt,
   output logic [ADDR_WIDTH-1:0]   AWADDR,
   output logic                    AWVALID,
   input  logic                    AWREADY,
   output logic [DATA_WIDTH-1:0]   WDATA,
   output logic [DATA_WIDTH/8-1:0] WSTRB,
   output logic                    WVALID,
   input  logic                    WREADY,
   input  logic [1:0]              BRESP,
   input  logic                    BVALID,
   output logic                    BREADY,
   output logic [ADDR_WIDTH-1:0]   ARADDR,
   output logic                    ARVALID,
   input  logic                    ARREADY,
   input  logic [DATA_WIDTH-1:0]   RDATA,
   input  logic [1:0]              RRESP,
   input  logic                    RVALID,
   output logic                    RREADY
);

   import sram_axil_pkg::*;

   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WR_REQ,
      S_WR_RESP,
      S_RD_REQ,
      S_RD_RESP,
      S_RSP
   } state_e;

   state_e                  state_q, state_d;
   logic [TW-1:0]           timer_q, timer_d;
   logic                    cmd_ready_q, cmd_ready_d;
   logic                    awvalid_q, awvalid_d;
   logic                    wvalid_q, wvalid_d;
   logic                    arvalid_q, arvalid_d;
   logic                    aw_done_q, aw_done_d;
   logic                    w_done_q, w_done_d;
   logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
   logic [ADDR_WIDTH-1:0]   araddr_q, araddr_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic [DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
   logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
   logic [1:0]              rsp_resp_q, rsp_resp_d;
   logic                    rsp_timeout_q, rsp_timeout_d;
   logic [7:0]              stray_q, stray_d;

   logic                    active;
   logic                    expire;
   logic                    aw_hs;
   logic                    w_hs;
   logic                    b_stray;
   logic                    r_stray;
   logic [8:0]              stray_sum;

   always_comb begin
      state_d       = state_q;
      timer_d       = timer_q;
      awvalid_d     = awvalid_q;
      wvalid_d      = wvalid_q;
      arvalid_d     = arvalid_q;
      aw_done_d     = aw_done_q;
      w_done_d      = w_done_q;
      awaddr_d      = awaddr_q;
      araddr_d      = araddr_q;
      wdata_d       = wdata_q;
      wstrb_d       = wstrb_q;
      rsp_rdata_d   = rsp_rdata_q;
      rsp_resp_d    = rsp_resp_q;
      rsp_timeout_d = rsp_timeout_q;
      aw_hs         = awvalid_q & AWREADY;
      w_hs          = wvalid_q & WREADY;

      active = (state_q == S_WR_REQ) || (state_q == S_WR_RESP)
            || (state_q == S_RD_REQ) || (state_q == S_RD_RESP);
      // Expire on the TIMEOUT-th cycle spent waiting on the slave.
      expire = active && (timer_q == T_LAST);
      if (active) begin
         timer_d = timer_q + 1'b1;
      end

      unique case (state_q)
         S_IDLE: begin
            if (cmd_valid && cmd_ready_q) begin
               timer_d = '0;
               if (cmd_write) begin
                  state_d   = S_WR_REQ;
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
                  aw_done_d = 1'b0;
                  w_done_d  = 1'b0;
                  awaddr_d  = cmd_addr;
                  wdata_d   = cmd_wdata;
                  wstrb_d   = cmd_wstrb;
               end else begin
                  state_d   = S_RD_REQ;
                  arvalid_d = 1'b1;
                  araddr_d  = cmd_addr;
               end
            end
         end
         S_WR_REQ: begin
            if (aw_hs) begin
               awvalid_d = 1'b0;
               aw_done_d = 1'b1;
            end
            if (w_hs) begin
               wvalid_d = 1'b0;
               w_done_d = 1'b1;
            end
            if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) begin
               state_d = S_WR_RESP;
            end
         end
         S_WR_RESP: begin
            if (BVALID) begin
               rsp_rdata_d   = '0;
               rsp_resp_d    = BRESP;
               rsp_timeout_d = 1'b0;
               state_d       = S_RSP;
            end
         end
         S_RD_REQ: begin
            if (arvalid_q && ARREADY) begin
               arvalid_d = 1'b0;
               state_d   = S_RD_RESP;
            end
         end
         S_RD_RESP: begin
            if (RVALID) begin
               rsp_rdata_d   = RDATA;
               rsp_resp_d    = RRESP;
               rsp_timeout_d = 1'b0;
               state_d       = S_RSP;
            end
         end
         S_RSP: begin
            if (rsp_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // A handshake in the expiry cycle has already moved state_d on.
      if (expire && (state_d == state_q)) begin
         awvalid_d     = 1'b0;
         wvalid_d      = 1'b0;
         arvalid_d     = 1'b0;
         rsp_rdata_d   = '0;
         rsp_resp_d    = AXI_RESP_SLVERR;
         rsp_timeout_d = 1'b1;
         state_d       = S_RSP;
      end

      cmd_ready_d = (state_d == S_IDLE);

      b_stray   = BVALID && (state_q != S_WR_RESP);
      r_stray   = RVALID && (state_q != S_RD_RESP);
      stray_sum = {1'b0, stray_q} + {8'd0, b_stray} + {8'd0, r_stray};
      stray_d   = stray_sum[8] ? 8'hFF : stray_sum[7:0];
   end

   always_ff @(posedge ACLK) begin
      if (!ARESETN) begin
         state_q       <= S_IDLE;
         timer_q       <= '0;
         cmd_ready_q   <= 1'b0;
         awvalid_q     <= 1'b0;
         wvalid_q      <= 1'b0;
         arvalid_q     <= 1'b0;
         aw_done_q     <= 1'b0;
         w_done_q      <= 1'b0;
         awaddr_q      <= '0;
         araddr_q      <= '0;
         wdata_q       <= '0;
         wstrb_q       <= '0;
         rsp_rdata_q   <= '0;
         rsp_resp_q    <= AXI_RESP_OK;
         rsp_timeout_q <= 1'b0;
         stray_q       <= '0;
      end else begin
         state_q       <= state_d;
         timer_q       <= timer_d;
         cmd_ready_q   <= cmd_ready_d;
         awvalid_q     <= awvalid_d;
         wvalid_q      <= wvalid_d;
         arvalid_q     <= arvalid_d;
         aw_done_q     <= aw_done_d;
         w_done_q      <= w_done_d;
         awaddr_q      <= awaddr_d;
         araddr_q      <= araddr_d;
         wdata_q       <= wdata_d;
         wstrb_q       <= wstrb_d;
         rsp_rdata_q   <= rsp_rdata_d;
         rsp_resp_q    <= rsp_resp_d;
         rsp_timeout_q <= rsp_timeout_d;
         stray_q       <= stray_d;
      end
   end

   // Response channels always sink so late or stray beats never stall.
   assign BREADY      = 1'b1;
   assign RREADY      = 1'b1;
   assign cmd_ready   = cmd_ready_q;
   assign rsp_valid   = (state_q == S_RSP);
   assign rsp_rdata   = rsp_rdata_q;
   assign rsp_resp    = rsp_resp_q;
   assign rsp_timeout = rsp_timeout_q;
   assign stray_cnt   = stray_q;
   assign AWADDR      = awaddr_q;
   assign AWVALID     = awvalid_q;
   assign WDATA       = wdata_q;
   assign WSTRB       = wstrb_q;
   assign WVALID      = wvalid_q;
   assign ARADDR      = araddr_q;
   assign ARVALID     = arvalid_q;

endmodule

// File: tb/tb_sram_regs_master.sv
// Bench for sram_regs_master: register-file slave model with selectable
// AW/W ordering, scoreboard queue of expected responses, separate monitor.
module tb_sram_regs_master;

   import sram_axil_pkg::*;

   logic        clk = 1'b0;
   logic        ARESETN = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic        cmd_write = 1'b0;
   logic [31:0] cmd_addr = '0;
   logic [31:0] cmd_wdata = '0;
   logic [3:0]  cmd_wstrb = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b1;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_resp;
   logic        rsp_timeout;
   logic [7:0]  stray_cnt;
   logic [31:0] AWADDR;
   logic        AWVALID;
   logic        AWREADY = 1'b0;
   logic [31:0] WDATA;
   logic [3:0]  WSTRB;
   logic        WVALID;
   logic        WREADY = 1'b0;
   logic [1:0]  BRESP = 2'b00;
   logic        BVALID;
   logic        BREADY;
   logic [31:0] ARADDR;
   logic        ARVALID;
   logic        ARREADY = 1'b0;
   logic [31:0] RDATA = '0;
   logic [1:0]  RRESP = 2'b00;
   logic        RVALID;
   logic        RREADY;

   logic        bvalid_s = 1'b0;
   logic        rvalid_s = 1'b0;
   logic        inj_b = 1'b0;
   assign BVALID = bvalid_s | inj_b;
   assign RVALID = rvalid_s;

   sram_regs_master #(
      .DATA_WIDTH(32),
      .ADDR_WIDTH(32),
      .TIMEOUT(16)
   ) dut (
      .ACLK(clk), .ARESETN(ARESETN),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_write(cmd_write), .cmd_addr(cmd_addr),
      .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
      .rsp_timeout(rsp_timeout), .stray_cnt(stray_cnt),
      .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
      .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
      .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
      .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
      .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   initial forever begin
      @(posedge clk);
      cyc = cyc + 1;
   end

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [31:0] rdata;
      logic [1:0]  resp;
      logic        tmo;
      int          lat;
      int          acc;
   } exp_t;

   exp_t exp_q[$];

   // Slave: 0 AW before W, 1 W before AW, 2 AW+W together, 3 AW stuck.
   int          mode = 0;
   int          aw_cnt = 0;
   int          w_cnt = 0;
   logic [31:0] mem [0:255];

   initial begin
      logic        aw_got, w_got, b_pend, r_pend;
      logic [31:0] aw_a, w_d, r_d;
      logic [3:0]  w_s;
      logic [1:0]  b_r, r_r;
      aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
      aw_a = 0; w_d = 0; w_s = 0; r_d = 0; b_r = 0; r_r = 0;
      for (int i = 0; i < 256; i++) mem[i] = '0;
      mem[REG_TAIL_0] = 32'h0000_1234;
      forever begin
         @(negedge clk);
         bvalid_s = 1'b0;
         rvalid_s = 1'b0;
         if (b_pend) begin
            bvalid_s = 1'b1; BRESP = b_r; b_pend = 0;
         end
         if (r_pend) begin
            rvalid_s = 1'b1; RDATA = r_d; RRESP = r_r; r_pend = 0;
         end
         case (mode)
            0: begin
               AWREADY = AWVALID && !aw_got;
               WREADY  = WVALID && aw_got && !w_got;
            end
            1: begin
               WREADY  = WVALID && !w_got;
               AWREADY = AWVALID && w_got && !aw_got;
            end
            2: begin
               AWREADY = AWVALID && WVALID;
               WREADY  = AWVALID && WVALID;
            end
            default: begin
               AWREADY = 1'b0;
               WREADY  = WVALID && !w_got;
            end
         endcase
         ARREADY = ARVALID;
         if (AWVALID && AWREADY) begin
            aw_got = 1; aw_a = AWADDR; aw_cnt = aw_cnt + 1;
         end
         if (WVALID && WREADY) begin
            w_got = 1; w_d = WDATA; w_s = WSTRB; w_cnt = w_cnt + 1;
         end
         if (aw_got && w_got) begin
            if (reg_is_mapped(aw_a)) begin
               for (int b = 0; b < 4; b++)
                  if (w_s[b]) mem[aw_a[7:0]][8*b +: 8] = w_d[8*b +: 8];
               b_r = AXI_RESP_OK;
            end else begin
               b_r = AXI_RESP_SLVERR;
            end
            b_pend = 1; aw_got = 0; w_got = 0;
         end else if (!AWVALID && !WVALID) begin
            aw_got = 0; w_got = 0;
         end
         if (ARVALID && ARREADY) begin
            r_pend = 1;
            if (reg_is_mapped(ARADDR)) begin
               r_d = mem[ARADDR[7:0]]; r_r = AXI_RESP_OK;
            end else begin
               r_d = '0; r_r = AXI_RESP_SLVERR;
            end
         end
      end
   end

   // Monitor: pops the scoreboard on every rsp handshake.
   initial begin
      logic        prev_v;
      int          first;
      logic [31:0] s_rdata;
      logic [1:0]  s_resp;
      logic        s_tmo;
      exp_t        e;
      prev_v = 0; first = 0; s_rdata = 0; s_resp = 0; s_tmo = 0;
      forever begin
         @(negedge clk);
         #2;
         if (ARESETN && rsp_valid) begin
            if (!prev_v) begin
               first = cyc;
               s_rdata = rsp_rdata; s_resp = rsp_resp; s_tmo = rsp_timeout;
               chk("axi_valids_in_rsp", {61'd0, AWVALID, WVALID, ARVALID}, 0);
            end else begin
               chk("rsp_stable", {29'd0, rsp_timeout, rsp_resp, rsp_rdata},
                   {29'd0, s_tmo, s_resp, s_rdata});
            end
            chk("cmd_ready_in_rsp", 64'(cmd_ready), 0);
            if (rsp_ready) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_rsp", 1, 0);
               end else begin
                  e = exp_q.pop_front();
                  chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
                  chk("rsp_resp", 64'(rsp_resp), 64'(e.resp));
                  chk("rsp_timeout", 64'(rsp_timeout), 64'(e.tmo));
                  chk("rsp_latency", 64'(first - e.acc), 64'(e.lat));
               end
            end
            prev_v = !rsp_ready;
         end else begin
            prev_v = 0;
         end
      end
   end

   task automatic issue(input logic wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] strb,
                        input logic [31:0] e_rdata, input logic [1:0] e_resp,
                        input logic e_tmo, input int e_lat, input bit push);
      int   n;
      exp_t e;
      @(negedge clk);
      #1;
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr;
      cmd_wdata = data; cmd_wstrb = strb;
      n = 0;
      while (!cmd_ready && n < 50) begin
         @(negedge clk);
         #1;
         n = n + 1;
      end
      chk("cmd_accept", 64'(cmd_ready), 1);
      if (cmd_ready && push) begin
         e.rdata = e_rdata; e.resp = e_resp; e.tmo = e_tmo;
         e.lat = e_lat; e.acc = cyc;
         exp_q.push_back(e);
      end
      @(negedge clk);
      #1;
      cmd_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 60) begin
         @(negedge clk);
         n = n + 1;
      end
      chk("rsp_drained", 64'(exp_q.size()), 0);
      exp_q.delete();
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1);
   end

   initial begin
      int a0, w0, n;
      @(negedge clk);
      #1;
      chk("rst_valids", {61'd0, AWVALID, WVALID, ARVALID}, 0);
      chk("rst_cmd_ready", 64'(cmd_ready), 0);
      chk("rst_readies", {62'd0, BREADY, RREADY}, 64'h3);
      chk("rst_rsp", {29'd0, rsp_valid, rsp_resp, rsp_timeout}, 0);
      chk("rst_rdata", 64'(rsp_rdata), 0);
      chk("rst_stray", 64'(stray_cnt), 0);
      chk("rst_addr", {AWADDR, ARADDR}, 0);
      chk("rst_wdata", {28'd0, WSTRB, WDATA}, 0);
      ARESETN = 1'b1;
      @(negedge clk);
      #1;
      chk("cmd_ready_after_rst", 64'(cmd_ready), 1);

      mode = 0;
      issue(1, 32'h10, 32'h0002_0000, 4'hF, 0, AXI_RESP_OK, 0, 4, 1);
      drain();
      issue(0, 32'h10, 0, 0, 32'h0002_0000, AXI_RESP_OK, 0, 3, 1);
      drain();
      issue(0, 32'h20, 0, 0, 32'h0000_1234, AXI_RESP_OK, 0, 3, 1);
      drain();
      issue(0, 32'h40, 0, 0, 0, AXI_RESP_SLVERR, 0, 3, 1);
      drain();
      issue(1, 32'h40, 32'h1, 4'hF, 0, AXI_RESP_SLVERR, 0, 4, 1);
      drain();

      mode = 3;
      issue(1, 32'h00, 32'hCAFE, 4'hF, 0, AXI_RESP_SLVERR, 1, 17, 1);
      drain();

      mode = 1;
      a0 = aw_cnt; w0 = w_cnt;
      issue(1, 32'h11, 32'hAB, 4'h1, 0, AXI_RESP_OK, 0, 4, 1);
      drain();
      chk("wfirst_aw_hs", 64'(aw_cnt - a0), 1);
      chk("wfirst_w_hs", 64'(w_cnt - w0), 1);

      mode = 2;
      a0 = aw_cnt; w0 = w_cnt;
      issue(1, 32'h12, 32'h55, 4'hF, 0, AXI_RESP_OK, 0, 3, 1);
      drain();
      chk("same_aw_hs", 64'(aw_cnt - a0), 1);
      chk("same_w_hs", 64'(w_cnt - w0), 1);
      issue(0, 32'h11, 0, 0, 32'hAB, AXI_RESP_OK, 0, 3, 1);
      drain();
      issue(0, 32'h12, 0, 0, 32'h55, AXI_RESP_OK, 0, 3, 1);
      drain();

      mode = 0;
      rsp_ready = 1'b0;
      issue(1, 32'h13, 32'h7, 4'hF, 0, AXI_RESP_OK, 0, 4, 1);
      n = 0;
      while (!rsp_valid && n < 40) begin
         @(negedge clk);
         #1;
         n = n + 1;
      end
      chk("stall_rsp_seen", 64'(rsp_valid), 1);
      repeat (5) @(negedge clk);
      #1;
      rsp_ready = 1'b1;
      drain();

      mode = 3;
      issue(1, 32'h02, 32'h9, 4'hF, 0, 0, 0, 0, 0);
      repeat (2) @(negedge clk);
      #1;
      chk("midwr_awvalid", 64'(AWVALID), 1);
      ARESETN = 1'b0;
      @(negedge clk);
      #1;
      chk("abort_valids", {61'd0, AWVALID, WVALID, ARVALID}, 0);
      chk("abort_rsp_valid", 64'(rsp_valid), 0);
      ARESETN = 1'b1;
      @(negedge clk);
      #1;
      chk("abort_cmd_ready", 64'(cmd_ready), 1);
      chk("stray_before", 64'(stray_cnt), 0);
      inj_b = 1'b1;
      @(negedge clk);
      #1;
      inj_b = 1'b0;
      chk("stray_after", 64'(stray_cnt), 1);
      repeat (3) @(negedge clk);
      chk("no_leftover_exp", 64'(exp_q.size()), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
